// File: rtl/bit_reorder_pkg.sv
// Shared types and helpers for the bit-order remapping deserializer.
package bit_reorder_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   // Width of the bit-position counter, which spans 0..n-1.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bit_reorder_map.sv
// Restores natural bit order: serial bit i lands at word[i] or word[N-1-i].
module bit_reorder_map
   import bit_reorder_pkg::*;
#(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b0
)
(
   input  logic [N-1:0] i_bits,
   output logic [N-1:0] o_word
);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_map
         if (MSB_FIRST) begin : g_msb
            assign o_word[N-1-gi] = i_bits[gi];
         end else begin : g_lsb
            assign o_word[gi] = i_bits[gi];
         end
      end
   endgenerate

endmodule

// File: rtl/bit_reorder_deser.sv
// Framed serial-to-parallel receiver: collects N bits starting at s_sof,
// remaps them to natural order and holds the word until m_ready.
module bit_reorder_deser
   import bit_reorder_pkg::*;
#(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b0
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   input  logic         s_data,
   input  logic         s_sof,
   output logic         s_ready,
   output logic         m_valid,
   output logic [N-1:0] m_data,
   input  logic         m_ready,
   output logic         frame_err,
   output logic         busy
);

   localparam int            CW       = cnt_w(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [N-1:0]   r_shift;
   logic           r_m_valid;
   logic [N-1:0]   r_m_data;
   logic           r_frame_err;

   state_t         w_state_next;
   logic [CW-1:0]  w_cnt_next;
   logic [N-1:0]   w_shift_next;
   logic           w_m_valid_next;
   logic           w_frame_err_next;
   logic           w_load;
   logic [N-1:0]   w_word;

   // The remap sees the shift value including the bit accepted this cycle,
   // so the final bit and the word load share one edge.
   bit_reorder_map #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_map (
      .i_bits (w_shift_next),
      .o_word (w_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_m_valid   <= 1'b0;
         r_m_data    <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_shift     <= w_shift_next;
         r_m_valid   <= w_m_valid_next;
         r_frame_err <= w_frame_err_next;
         if (w_load) begin
            r_m_data <= w_word;
         end
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_shift_next     = r_shift;
      w_m_valid_next   = r_m_valid;
      w_frame_err_next = 1'b0;
      w_load           = 1'b0;
      case (r_state)
         IDLE: begin
            if (s_valid) begin
               if (s_sof) begin
                  w_shift_next    = '0;
                  w_shift_next[0] = s_data;
                  w_cnt_next      = CNT_ONE;
                  w_state_next    = SHIFT;
               end else begin
                  w_frame_err_next = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (s_valid) begin
               if (s_sof) begin
                  // Early start-of-frame: flag it and treat this bit as a fresh word.
                  w_frame_err_next = 1'b1;
                  w_shift_next     = '0;
                  w_shift_next[0]  = s_data;
                  w_cnt_next       = CNT_ONE;
               end else begin
                  w_shift_next[r_cnt] = s_data;
                  if (r_cnt == CNT_LAST) begin
                     w_state_next   = HOLD;
                     w_cnt_next     = '0;
                     w_m_valid_next = 1'b1;
                     w_load         = 1'b1;
                  end else begin
                     w_cnt_next = r_cnt + CNT_ONE;
                  end
               end
            end
         end
         HOLD: begin
            if (m_ready) begin
               w_state_next   = IDLE;
               w_m_valid_next = 1'b0;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign s_ready   = (r_state != HOLD);
   assign busy      = (r_state != IDLE);
   assign m_valid   = r_m_valid;
   assign m_data    = r_m_data;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_bit_reorder_deser.sv
// Directed bench for bit_reorder_deser: LSB-first and MSB-first instances share
// stimulus and are checked every cycle against a bit-list model plus literals.
module tb_bit_reorder_deser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_data = 1'b0;
   logic       s_sof = 1'b0;
   logic       m_ready = 1'b0;

   logic       s_ready0, m_valid0, frame_err0, busy0;
   logic [7:0] m_data0;
   logic       s_ready1, m_valid1, frame_err1, busy1;
   logic [7:0] m_data1;

   int n_cmp = 0;
   int n_bad = 0;
   int fe_cnt = 0;
   int fe_base = 0;
   bit chk_en = 1'b0;

   // Model state: list of bits of the current frame, and the last completed word.
   bit       md_active = 1'b0;
   bit       md_hold = 1'b0;
   bit       md_fe = 1'b0;
   bit [7:0] md_lsb = 8'h00;
   bit [7:0] md_msb = 8'h00;
   bit       md_q[$];

   always #5 clk = ~clk;

   bit_reorder_deser #(.N(8), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
      .s_ready(s_ready0), .m_valid(m_valid0), .m_data(m_data0), .m_ready(m_ready),
      .frame_err(frame_err0), .busy(busy0)
   );

   bit_reorder_deser #(.N(8), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
      .s_ready(s_ready1), .m_valid(m_valid1), .m_data(m_data1), .m_ready(m_ready),
      .frame_err(frame_err1), .busy(busy1)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         md_q.delete();
         md_active = 1'b0;
         md_hold   = 1'b0;
         md_fe     = 1'b0;
         md_lsb    = 8'h00;
         md_msb    = 8'h00;
      end else begin
         md_fe = 1'b0;
         if (md_hold) begin
            if (m_ready) md_hold = 1'b0;
         end else if (s_valid) begin
            if (s_sof) begin
               md_fe = md_active;
               md_q.delete();
               md_q.push_back(s_data);
               md_active = 1'b1;
            end else if (!md_active) begin
               md_fe = 1'b1;
            end else begin
               md_q.push_back(s_data);
            end
            if (md_active && md_q.size() == 8) begin
               for (int i = 0; i < 8; i++) begin
                  md_lsb[i]   = md_q[i];
                  md_msb[7-i] = md_q[i];
               end
               md_hold   = 1'b1;
               md_active = 1'b0;
               md_q.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk1("s_ready0",   s_ready0,   !md_hold);
         chk1("m_valid0",   m_valid0,   md_hold);
         chk8("m_data0",    m_data0,    md_lsb);
         chk1("frame_err0", frame_err0, md_fe);
         chk1("busy0",      busy0,      md_active || md_hold);
         chk1("s_ready1",   s_ready1,   !md_hold);
         chk1("m_valid1",   m_valid1,   md_hold);
         chk8("m_data1",    m_data1,    md_msb);
         chk1("frame_err1", frame_err1, md_fe);
         chk1("busy1",      busy1,      md_active || md_hold);
         if (frame_err0) fe_cnt++;
      end
   end

   task automatic step(input logic v, input logic d, input logic sof);
      s_valid = v;
      s_data  = d;
      s_sof   = sof;
      @(posedge clk);
      #1;
   endtask

   // Sends w[0] first; gap>0 inserts 1..gap idle cycles before middle bits.
   task automatic send_word(input logic [7:0] w, input int gap);
      for (int i = 0; i < 8; i++) begin
         if (gap > 0 && i > 0 && i < 7) repeat (1 + (i % gap)) step(1'b0, 1'b0, 1'b0);
         if (i == 7) chk1("pre_last_mvalid", m_valid0, 1'b0);
         step(1'b1, w[i], i == 0);
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic release_word();
      m_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      m_ready = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      chk1("rst_mvalid", m_valid0, 1'b0);
      chk8("rst_mdata", m_data0, 8'h00);
      chk1("rst_fe", frame_err0, 1'b0);
      chk1("rst_busy", busy0, 1'b0);
      chk1("rst_sready", s_ready0, 1'b1);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0);

      // Bits 1,0,1,1,0,0,1,0 in arrival order.
      send_word(8'h4D, 0);
      chk1("t1_mvalid", m_valid0, 1'b1);
      chk8("t1_lsb_data", m_data0, 8'h4D);
      chk8("t2_msb_data", m_data1, 8'hB2);

      repeat (5) begin
         step(1'b0, 1'b0, 1'b0);
         chk8("t3_hold_data", m_data0, 8'h4D);
         chk1("t3_hold_sready", s_ready0, 1'b0);
         chk1("t3_hold_mvalid", m_valid0, 1'b1);
      end
      release_word();
      chk1("t3_rel_mvalid", m_valid0, 1'b0);
      chk1("t3_rel_sready", s_ready0, 1'b1);

      fe_base = fe_cnt;
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      chk1("t4_fe_pulse", frame_err0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (i == 0) chk1("t4_fe_single", frame_err0, 1'b0);
      end
      s_valid = 1'b0;
      chk8("t4_data", m_data0, 8'hFF);
      chk1("t4_mvalid", m_valid0, 1'b1);
      release_word();
      chk1("t4_fe_count", (fe_cnt - fe_base) == 1, 1'b1);

      fe_base = fe_cnt;
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      chk1("t5_rst_mvalid", m_valid0, 1'b0);
      chk8("t5_rst_mdata", m_data0, 8'h00);
      chk1("t5_rst_busy", busy0, 1'b0);
      send_word(8'hA5, 0);
      chk8("t5_lsb_data", m_data0, 8'hA5);
      chk8("t5_msb_data", m_data1, 8'hA5);
      release_word();
      chk1("t5_no_fe", fe_cnt == fe_base, 1'b1);

      fe_base = fe_cnt;
      repeat (3) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk1("t6_fe_count", (fe_cnt - fe_base) == 3, 1'b1);
      chk1("t6_mvalid", m_valid0, 1'b0);
      send_word(8'h4D, 3);
      chk8("t6_gap_lsb", m_data0, 8'h4D);
      chk8("t6_gap_msb", m_data1, 8'hB2);
      release_word();

      send_word(8'h01, 2);
      chk8("t7_lsb_data", m_data0, 8'h01);
      chk8("t7_msb_data", m_data1, 8'h80);
      release_word();
      step(1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
